// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: waits for configuration, skips the first unstable frames, packs byte
// pairs into RGB565 pixels with x/y coordinates, and flags frames whose geometry is off.
module ov5640_dvp_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_ACT       = 960,
  parameter int V_ACT       = 540
) (
  input  logic        cam_pclk,
  input  logic        camera_rst,
  input  logic        reg_conf_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        line_end,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        frame_err,
  output logic        capturing
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, CAPTURE} state_e;

  typedef struct packed {
    logic        valid;
    logic        start;
    logic        lend;
    logic        err;
    logic [15:0] data;
    logic [10:0] x;
    logic [9:0]  y;
  } pix_t;

  localparam logic [10:0] X_LAST    = 11'(H_ACT - 1);
  localparam logic [10:0] X_FULL    = 11'(H_ACT);
  localparam logic [9:0]  Y_LAST    = 10'(V_ACT - 1);
  localparam logic [9:0]  Y_FULL    = 10'(V_ACT);
  localparam logic [7:0]  SKIP_LAST = 8'(SKIP_FRAMES - 1);

  logic        conf_meta_q, conf_sync_q;
  logic        vsync_r_q, vsync_rr_q, href_r_q, href_rr_q;
  logic [7:0]  data_r_q;
  state_e      state_q, state_d;
  logic [7:0]  skip_q, skip_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  ln_q, ln_d;
  logic        bad_q, bad_d;
  logic        fs_pend_q, fs_pend_d;
  pix_t        pix_q, pix_d;
  pix_t        out_q, out_d;

  logic vs_rise, href_fall, href_rise, ph;

  assign vs_rise   = vsync_r_q & ~vsync_rr_q;
  assign href_fall = ~href_r_q & href_rr_q;
  assign href_rise = href_r_q & ~href_rr_q;

  // NOTE: every register is written with <= so all flops sample the pre-edge values together.
  always_ff @(posedge cam_pclk or posedge camera_rst) begin
    if (camera_rst) begin
      conf_meta_q <= 1'b0;
      conf_sync_q <= 1'b0;
      vsync_r_q   <= 1'b0;
      vsync_rr_q  <= 1'b0;
      href_r_q    <= 1'b0;
      href_rr_q   <= 1'b0;
      data_r_q    <= '0;
      state_q     <= IDLE;
      skip_q      <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      px_q        <= '0;
      ln_q        <= '0;
      bad_q       <= 1'b0;
      fs_pend_q   <= 1'b0;
      pix_q       <= '0;
      out_q       <= '0;
    end else begin
      conf_meta_q <= reg_conf_done;
      conf_sync_q <= conf_meta_q;
      vsync_r_q   <= cam_vsync;
      vsync_rr_q  <= vsync_r_q;
      href_r_q    <= cam_href;
      href_rr_q   <= href_r_q;
      data_r_q    <= cam_data;
      state_q     <= state_d;
      skip_q      <= skip_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      px_q        <= px_d;
      ln_q        <= ln_d;
      bad_q       <= bad_d;
      fs_pend_q   <= fs_pend_d;
      pix_q       <= pix_d;
      out_q       <= out_d;
    end
  end

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    px_d      = px_q;
    ln_d      = ln_q;
    bad_d     = bad_q;
    fs_pend_d = fs_pend_q;
    pix_d       = pix_q;
    pix_d.valid = 1'b0;
    pix_d.start = 1'b0;
    pix_d.lend  = 1'b0;
    pix_d.err   = 1'b0;
    ph        = href_rise ? 1'b0 : phase_q;

    case (state_q)
      IDLE:    if (conf_sync_q) state_d = WAIT_VS;
      WAIT_VS: if (vs_rise) begin
        state_d = SKIP;
        skip_d  = '0;
      end
      SKIP:    if (vs_rise) begin
        if (skip_q == SKIP_LAST) state_d = CAPTURE;
        else                     skip_d  = skip_q + 8'd1;
      end
      CAPTURE: state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
    if (!conf_sync_q) begin
      state_d = IDLE;
      skip_d  = '0;
    end

    // Gate on the next state so a line starting on the vs_rise that enters capture is kept.
    if (state_d == CAPTURE) begin
      if (href_r_q) begin
        if (!ph) begin
          hi_d    = data_r_q;
          phase_d = 1'b1;
        end else begin
          phase_d     = 1'b0;
          pix_d.valid = 1'b1;
          pix_d.data  = {hi_q, data_r_q};
          pix_d.x     = (px_q >= X_FULL) ? X_LAST : px_q;
          pix_d.y     = (ln_q >= Y_FULL) ? Y_LAST : ln_q;
          pix_d.lend  = (pix_d.x == X_LAST);
          pix_d.start = fs_pend_q && (pix_d.x == '0) && (pix_d.y == '0);
          fs_pend_d   = 1'b0;
          if (px_q >= X_FULL || ln_q >= Y_FULL) bad_d = 1'b1;
          if (px_q < X_FULL) px_d = px_q + 11'd1;
        end
      end
      if (href_fall) begin
        // A set phase here means a dangling high byte, which is simply dropped.
        if (phase_q || px_q != X_FULL) bad_d = 1'b1;
        phase_d = 1'b0;
        px_d    = '0;
        if (ln_q < Y_FULL) ln_d = ln_q + 10'd1;
      end
      if (vs_rise) begin
        if (state_q == CAPTURE && (bad_d || ln_d != Y_FULL)) pix_d.err = 1'b1;
        bad_d     = 1'b0;
        ln_d      = '0;
        fs_pend_d = 1'b1;
      end
    end else begin
      phase_d   = 1'b0;
      px_d      = '0;
      ln_d      = '0;
      bad_d     = 1'b0;
      fs_pend_d = 1'b0;
      pix_d     = '0;
    end

    out_d = conf_sync_q ? pix_q : '0;
  end

  assign pix_data    = out_q.data;
  assign pix_valid   = out_q.valid;
  assign frame_start = out_q.start;
  assign line_end    = out_q.lend;
  assign x_cnt       = out_q.x;
  assign y_cnt       = out_q.y;
  assign frame_err   = out_q.err;
  assign capturing   = (state_q == CAPTURE);

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Bench for ov5640_dvp_capture on a reduced 16x4 geometry with two skipped frames; expected
// pixels are queued as bytes are driven and compared as the DUT strobes them.
module tb_ov5640_dvp_capture;

  localparam int SKIP = 2;
  localparam int H    = 16;
  localparam int V    = 4;

  logic        clk = 1'b0;
  logic        rst, conf, vs, href;
  logic [7:0]  data;
  logic [15:0] pix_data;
  logic        pix_valid, frame_start, line_end, frame_err, capturing;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;

  always #5 clk = ~clk;

  ov5640_dvp_capture #(.SKIP_FRAMES(SKIP), .H_ACT(H), .V_ACT(V)) dut (
    .cam_pclk(clk), .camera_rst(rst), .reg_conf_done(conf), .cam_vsync(vs), .cam_href(href),
    .cam_data(data), .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
    .line_end(line_end), .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_err(frame_err),
    .capturing(capturing)
  );

  typedef struct {
    logic [15:0] data;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fs;
    logic        le;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0, tests_failed = 0;
  int   cyc = 0;
  int   pv_seen = 0, fs_seen = 0, err_seen = 0;
  bit   sb_off = 1'b0, cap_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (pix_valid)   pv_seen++;
    if (frame_start) fs_seen++;
    if (frame_err)   err_seen++;
    if (pix_valid && !sb_off) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pixel: pix_valid=1 at cycle %0d x=%0d y=%0d, required no pixel",
                 cyc, x_cnt, y_cnt);
      end else begin
        e = sb_q.pop_front();
        if ({pix_data, x_cnt, y_cnt, frame_start, line_end} !== {e.data, e.x, e.y, e.fs, e.le}
            || cyc != e.cyc) begin
          tests_failed++;
          $display("FAIL pixel: got data=%h x=%0d y=%0d fs=%b le=%b cyc=%0d, required data=%h x=%0d y=%0d fs=%b le=%b cyc=%0d",
                   pix_data, x_cnt, y_cnt, frame_start, line_end, cyc,
                   e.data, e.x, e.y, e.fs, e.le, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic send_line(input int nbytes, input int l, input bit pat);
    logic [7:0] hi, b8;
    exp_t e;
    int p;
    hi = '0;
    for (int b = 0; b < nbytes; b++) begin
      @(negedge clk);
      b8   = pat ? ((b % 2 == 1) ? 8'h1F : 8'hF8) : 8'($urandom);
      href = 1'b1;
      data = b8;
      if (b % 2 == 0) hi = b8;
      else if (cap_now) begin
        p      = b / 2;
        e.data = {hi, b8};
        e.x    = 11'((p >= H) ? H - 1 : p);
        e.y    = 10'((l >= V) ? V - 1 : l);
        e.le   = (e.x == 11'(H - 1));
        e.fs   = (p == 0 && l == 0);
        e.cyc  = cyc + 3;
        sb_q.push_back(e);
      end
    end
    repeat (4) begin
      @(negedge clk);
      href = 1'b0;
      data = 8'($urandom);
    end
  endtask

  task automatic send_vsync();
    repeat (3) begin @(negedge clk); vs = 1'b1; href = 1'b0; end
    repeat (3) begin @(negedge clk); vs = 1'b0; end
  endtask

  task automatic send_frame(input int nlines, input int odd_line, input int odd_bytes, input bit pat);
    send_vsync();
    for (int l = 0; l < nlines; l++) send_line((l == odd_line) ? odd_bytes : 2 * H, l, pat);
  endtask

  task automatic test_reset();
    rst = 1'b1; conf = 1'b0; vs = 1'b0; href = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({pix_data, pix_valid, frame_start, line_end, x_cnt, y_cnt, frame_err, capturing} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h pv=%b x=%0d y=%0d cap=%b, required all zero",
               pix_data, pix_valid, x_cnt, y_cnt, capturing);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_conf();
    int pv0 = pv_seen;
    cap_now = 1'b0;
    repeat (3) send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (pv_seen - pv0 != 0 || capturing !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_conf: got %0d pixels capturing=%b, required 0 pixels capturing=0",
               pv_seen - pv0, capturing);
    end
  endtask

  task automatic test_skip_capture();
    int pv0, fs0, err0;
    conf = 1'b1;
    repeat (4) @(negedge clk);
    pv0 = pv_seen; fs0 = fs_seen; err0 = err_seen;
    cap_now = 1'b0;
    repeat (SKIP) send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (capturing !== 1'b0 || pv_seen != pv0) begin
      tests_failed++;
      $display("FAIL skip_frames: got capturing=%b pixels=%0d, required capturing=0 pixels=0",
               capturing, pv_seen - pv0);
    end
    cap_now = 1'b1;
    repeat (2) send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (fs_seen - fs0 != 2 || pv_seen - pv0 != 2 * H * V || err_seen != err0) begin
      tests_failed++;
      $display("FAIL capture_counts: got fs=%0d pv=%0d err=%0d, required fs=2 pv=%0d err=0",
               fs_seen - fs0, pv_seen - pv0, err_seen - err0, 2 * H * V);
    end
    tests_run++;
    if (capturing !== 1'b1 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL capture_state: got capturing=%b pending=%0d, required capturing=1 pending=0",
               capturing, sb_q.size());
    end
  endtask

  task automatic test_pattern();
    int pv0 = pv_seen, fs0 = fs_seen, err0 = err_seen;
    send_frame(V, -1, 0, 1'b1);
    tests_run++;
    if (pv_seen - pv0 != H * V || fs_seen - fs0 != 1 || err_seen != err0) begin
      tests_failed++;
      $display("FAIL pattern_frame: got pv=%0d fs=%0d err=%0d, required pv=%0d fs=1 err=0",
               pv_seen - pv0, fs_seen - fs0, err_seen - err0, H * V);
    end
  endtask

  task automatic test_dangling();
    int err0;
    send_frame(V, 1, 2 * H - 1, 1'b0);
    err0 = err_seen;
    send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (err_seen - err0 != 1) begin
      tests_failed++;
      $display("FAIL dangling_err: got %0d frame_err pulses, required 1", err_seen - err0);
    end
    err0 = err_seen;
    send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (err_seen != err0) begin
      tests_failed++;
      $display("FAIL good_after_bad: got %0d frame_err pulses, required 0", err_seen - err0);
    end
  endtask

  task automatic test_short_frame();
    int err0;
    send_frame(V - 1, -1, 0, 1'b0);
    err0 = err_seen;
    send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (err_seen - err0 != 1) begin
      tests_failed++;
      $display("FAIL short_frame_err: got %0d frame_err pulses, required 1", err_seen - err0);
    end
  endtask

  task automatic test_long_line();
    int err0, pv0;
    pv0 = pv_seen;
    send_frame(V, 2, 2 * (H + 4), 1'b0);
    tests_run++;
    if (pv_seen - pv0 != H * V + 4) begin
      tests_failed++;
      $display("FAIL long_line_count: got %0d pixels, required %0d", pv_seen - pv0, H * V + 4);
    end
    err0 = err_seen;
    send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (err_seen - err0 != 1) begin
      tests_failed++;
      $display("FAIL long_line_err: got %0d frame_err pulses, required 1", err_seen - err0);
    end
  endtask

  task automatic test_skip_restart();
    int pv0 = pv_seen, fs0 = fs_seen;
    cap_now = 1'b0;
    repeat (SKIP) send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (pv_seen != pv0) begin
      tests_failed++;
      $display("FAIL restart_skip: got %0d pixels during skip, required 0", pv_seen - pv0);
    end
    cap_now = 1'b1;
    send_frame(V, -1, 0, 1'b0);
    tests_run++;
    if (pv_seen - pv0 != H * V || fs_seen - fs0 != 1) begin
      tests_failed++;
      $display("FAIL restart_capture: got pv=%0d fs=%0d, required pv=%0d fs=1",
               pv_seen - pv0, fs_seen - fs0, H * V);
    end
  endtask

  task automatic test_conf_drop();
    int pv0;
    cap_now = 1'b1;
    fork
      send_frame(V, -1, 0, 1'b0);
      begin
        repeat (6 + 2 * (2 * H + 4) + 10) @(negedge clk);
        sb_off = 1'b1;
        conf   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cap_now = 1'b0;
        sb_q.delete();
        sb_off  = 1'b0;
      end
    join
    pv0 = pv_seen;
    repeat (20) @(negedge clk);
    tests_run++;
    if (capturing !== 1'b0 || pv_seen != pv0) begin
      tests_failed++;
      $display("FAIL conf_drop: got capturing=%b pixels=%0d, required capturing=0 pixels=0",
               capturing, pv_seen - pv0);
    end
    conf = 1'b1;
    repeat (4) @(negedge clk);
    test_skip_restart();
  endtask

  task automatic test_reset_mid_line();
    cap_now = 1'b1;
    fork
      send_frame(V, -1, 0, 1'b0);
      begin
        repeat (50) @(negedge clk);
        sb_off = 1'b1;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({pix_data, pix_valid, frame_start, line_end, x_cnt, y_cnt, frame_err, capturing} !== '0) begin
          tests_failed++;
          $display("FAIL reset_mid_line: got data=%h pv=%b x=%0d y=%0d cap=%b, required all zero",
                   pix_data, pix_valid, x_cnt, y_cnt, capturing);
        end
        cap_now = 1'b0;
      end
    join
    sb_q.delete();
    @(negedge clk);
    rst    = 1'b0;
    sb_off = 1'b0;
    repeat (4) @(negedge clk);
    test_skip_restart();
  endtask

  initial begin
    test_reset();
    test_no_conf();
    test_skip_capture();
    test_pattern();
    test_dangling();
    test_short_frame();
    test_long_line();
    test_conf_drop();
    test_reset_mid_line();
    repeat (5) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_pixels: got %0d expected pixels never strobed, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
